// File: rtl/rc_pulse_capture_pkg.sv
// ---------------------------------------------------------------------------
// rc_pulse_capture_pkg
//
// Shared constants and types for the RC servo pulse capture block.
//   - Pulse width window (in ticks) that produces a valid capture.
//   - Width and gap counter saturation limits.
//   - Status register addresses.
//   - Per-channel FSM state type.
//   - Helper deciding whether a measured width is inside the capture window.
// ---------------------------------------------------------------------------
package rc_pulse_capture_pkg;

    localparam logic [8:0]  PULSE_MIN = 9'd48;
    localparam logic [8:0]  PULSE_MAX = 9'd303;
    localparam logic [8:0]  WIDTH_SAT = 9'd511;
    localparam logic [11:0] GAP_MAX   = 12'd4095;

    localparam logic [4:0] ADDR_VALID     = 5'h10;
    localparam logic [4:0] ADDR_NEW       = 5'h11;
    localparam logic [4:0] ADDR_RANGE_ERR = 5'h12;
    localparam logic [4:0] ADDR_LOST      = 5'h13;

    typedef enum logic [1:0] {
        CH_SYNC    = 2'd0,
        CH_ARMED   = 2'd1,
        CH_MEASURE = 2'd2
    } chState_t;

    function automatic logic widthInRange(input logic [8:0] width);
        return (width >= PULSE_MIN) && (width <= PULSE_MAX);
    endfunction

endpackage

// File: rtl/rc_pulse_channel.sv
// ---------------------------------------------------------------------------
// rc_pulse_channel
//
// One RC servo pulse measurement channel: input synchronizer, SYNC/ARMED/
// MEASURE state machine, width counter and gap (pulse-to-pulse) watchdog.
//
// Ports
//   i_clock    : clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_tick     : one-cycle measurement tick from the shared prescaler
//   i_pulse    : asynchronous pulse input
//   o_value    : last valid capture, 303 - width in ticks
//   o_capture  : one-cycle pulse, a new in-window value was just loaded
//   o_rangeErr : one-cycle pulse, a pulse ended outside the width window
//   o_lost     : one-cycle pulse, no rising edge seen for GAP_MAX ticks
// ---------------------------------------------------------------------------
module rc_pulse_channel
    import rc_pulse_capture_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_pulse,
    output logic [7:0] o_value,
    output logic       o_capture,
    output logic       o_rangeErr,
    output logic       o_lost
);

    logic        r_meta;
    logic        r_level;
    chState_t    r_state;
    logic [8:0]  r_width;
    logic [11:0] r_gap;

    logic w_rise;
    logic w_gapExpire;

    // A rising edge is only meaningful once the channel has seen the input
    // low, which the ARMED state guarantees.
    assign w_rise      = (r_state == CH_ARMED) && r_level;

    // The watchdog fires once, on the tick that moves the gap counter onto its
    // saturation value; after that it sits at GAP_MAX until the next rising
    // edge, so a channel recovering from loss is not kicked back to SYNC.
    assign w_gapExpire = i_tick && !w_rise && (r_gap == (GAP_MAX - 12'd1));

    // Two-flop synchronizer. Deliberately not reset: while Reset is held the
    // flops keep following the pin, so a pulse already high at reset release
    // is seen as high and SYNC waits for it to end instead of mistaking the
    // cleared flops for a low level.
    always_ff @(posedge i_clock) begin
        r_meta  <= i_pulse;
        r_level <= r_meta;
    end

    // Channel state machine with its counters and registered event outputs.
    // The gap counter runs in every state; the width counter only advances
    // while a pulse is being measured. A pulse ending inside the window loads
    // the value, otherwise only the range error event is raised.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= CH_SYNC;
            r_width    <= '0;
            r_gap      <= '0;
            o_value    <= '0;
            o_capture  <= 1'b0;
            o_rangeErr <= 1'b0;
            o_lost     <= 1'b0;
        end else begin
            o_capture  <= 1'b0;
            o_rangeErr <= 1'b0;
            o_lost     <= 1'b0;

            if (w_rise) begin
                r_gap <= '0;
            end else if (i_tick && (r_gap != GAP_MAX)) begin
                r_gap <= r_gap + 12'd1;
            end

            if (w_gapExpire) begin
                r_state <= CH_SYNC;
                o_lost  <= 1'b1;
            end else begin
                case (r_state)
                    CH_SYNC: begin
                        if (!r_level) begin
                            r_state <= CH_ARMED;
                        end
                    end
                    CH_ARMED: begin
                        if (r_level) begin
                            r_state <= CH_MEASURE;
                            r_width <= '0;
                        end
                    end
                    CH_MEASURE: begin
                        if (!r_level) begin
                            r_state <= CH_ARMED;
                            if (widthInRange(r_width)) begin
                                o_value   <= 8'(PULSE_MAX - r_width);
                                o_capture <= 1'b1;
                            end else begin
                                o_rangeErr <= 1'b1;
                            end
                        end else if (i_tick && (r_width != WIDTH_SAT)) begin
                            r_width <= r_width + 9'd1;
                        end
                    end
                    default: begin
                        r_state <= CH_SYNC;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/rc_pulse_capture.sv
// ---------------------------------------------------------------------------
// rc_pulse_capture
//
// Multi-channel RC servo pulse width capture with a small register interface.
// A shared prescaler produces the measurement tick; each channel is measured
// independently by rc_pulse_channel. Status flags live here so that bus
// write-1-to-clear and hardware set events are resolved in one place.
//
// Ports
//   Clk    : clock, rising edge
//   Reset  : synchronous active-high reset
//   Addr   : register address
//   DataRd : registered read data, follows Addr with one cycle latency
//   DataWr : write data
//   En     : block select, qualifies Wr
//   Wr     : one-cycle write strobe
//   PIn    : asynchronous pulse inputs, one per channel
//
// Register map
//   0x00..NUM_CH/2-1 : {Value[2i+1], Value[2i]}
//   0x10 Valid, 0x11 New (W1C), 0x12 RangeErr (W1C), 0x13 Lost (W1C)
//   anything else reads 0
// ---------------------------------------------------------------------------
module rc_pulse_capture
    import rc_pulse_capture_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int TICK_DIV = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [4:0]        Addr,
    output logic [15:0]       DataRd,
    input  logic [15:0]       DataWr,
    input  logic              En,
    input  logic              Wr,
    input  logic [NUM_CH-1:0] PIn
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0] CH_MASK = 16'((1 << NUM_CH) - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    logic [7:0]         w_value [NUM_CH];
    logic [NUM_CH-1:0]  w_capture;
    logic [NUM_CH-1:0]  w_rangeErr;
    logic [NUM_CH-1:0]  w_lost;

    logic [15:0] w_capSet;
    logic [15:0] w_rangeSet;
    logic [15:0] w_lostSet;
    logic        w_wrEn;
    logic [15:0] w_clrNew;
    logic [15:0] w_clrRange;
    logic [15:0] w_clrLost;
    logic [15:0] w_rdNext;

    logic [15:0] r_valid;
    logic [15:0] r_new;
    logic [15:0] r_rangeErr;
    logic [15:0] r_lost;

    assign w_tick = (r_presc == PRESC_LAST);

    // Free-running prescaler; the tick is the cycle on which it wraps.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : gChannel
            rc_pulse_channel uChannel (
                .i_clock    (Clk),
                .i_reset    (Reset),
                .i_tick     (w_tick),
                .i_pulse    (PIn[g]),
                .o_value    (w_value[g]),
                .o_capture  (w_capture[g]),
                .o_rangeErr (w_rangeErr[g]),
                .o_lost     (w_lost[g])
            );
        end
    endgenerate

    // Widen the per-channel event pulses to the 16-bit register width and
    // decode the write-1-to-clear masks for the three sticky registers.
    always_comb begin
        w_capSet   = '0;
        w_rangeSet = '0;
        w_lostSet  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_capSet[i]   = w_capture[i];
            w_rangeSet[i] = w_rangeErr[i];
            w_lostSet[i]  = w_lost[i];
        end
        w_wrEn     = En && Wr;
        w_clrNew   = (w_wrEn && (Addr == ADDR_NEW))       ? DataWr : '0;
        w_clrRange = (w_wrEn && (Addr == ADDR_RANGE_ERR)) ? DataWr : '0;
        w_clrLost  = (w_wrEn && (Addr == ADDR_LOST))      ? DataWr : '0;
    end

    // Status flags. The clear is applied before the set so a hardware event
    // in the same cycle as a bus clear leaves the bit set. Bits above NUM_CH
    // are held at zero by the channel mask.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid    <= '0;
            r_new      <= '0;
            r_rangeErr <= '0;
            r_lost     <= '0;
        end else begin
            r_valid    <= ((r_valid    & ~w_lostSet)  | w_capSet)   & CH_MASK;
            r_new      <= ((r_new      & ~w_clrNew)   | w_capSet)   & CH_MASK;
            r_rangeErr <= ((r_rangeErr & ~w_clrRange) | w_rangeSet) & CH_MASK;
            r_lost     <= ((r_lost     & ~w_clrLost)  | w_lostSet)  & CH_MASK;
        end
    end

    // Read decode: value pairs at the low addresses, flag registers at 0x10
    // and up, zero everywhere else.
    always_comb begin
        w_rdNext = '0;
        case (Addr)
            ADDR_VALID:     w_rdNext = r_valid;
            ADDR_NEW:       w_rdNext = r_new;
            ADDR_RANGE_ERR: w_rdNext = r_rangeErr;
            ADDR_LOST:      w_rdNext = r_lost;
            default: begin
                for (int i = 0; i < NUM_CH / 2; i++) begin
                    if (Addr == 5'(i)) begin
                        w_rdNext = {w_value[2*i+1], w_value[2*i]};
                    end
                end
            end
        endcase
    end

    // Read data is registered every cycle; reads have no side effects.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataRd <= '0;
        end else begin
            DataRd <= w_rdNext;
        end
    end

endmodule
